// File: rtl/adc3wire_pkg.sv
// rtl/adc3wire_pkg.sv - shared types and sizing helpers for the 3-wire ADC configuration engine
//
// Contents:
//   state_t      per-channel sequencer state
//   frame_width  total serial frame length (preamble + address + data)
//   cnt_width    counter width able to hold values 0..n-1 (never below 1)
package adc3wire_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    function automatic int frame_width(input int preamble_w, input int addr_w, input int data_w);
        return preamble_w + addr_w + data_w;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc3wire_engine.sv
// rtl/adc3wire_engine.sv - one channel of the 3-wire serial configuration engine
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock and synchronous active-low reset
//   cfg_valid_i / cfg_ready_o    request handshake (ready = engine idle)
//   cfg_read_i, cfg_addr_i,
//   cfg_data_i                   request fields, latched at acceptance
//   rd_valid_o                   one-cycle completion pulse (read or write)
//   rd_data_o                    last readback word, held until the next read completes
//   busy_o                       engine not idle
//   sclk_o, sdata_o, sdata_oe_o,
//   sdata_i, strobe_n_o          serial pins
module adc3wire_engine
    import adc3wire_pkg::*;
#(
    parameter int                    ADDR_W       = 4,
    parameter int                    DATA_W       = 16,
    parameter int                    PREAMBLE_W   = 12,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE_VAL = 12'h001,
    parameter int                    CLK_DIV      = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic              cfg_read_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              sdata_o,
    output logic              sdata_oe_o,
    input  logic              sdata_i,
    output logic              strobe_n_o
);

    localparam int FRAME_W = frame_width(PREAMBLE_W, ADDR_W, DATA_W);
    localparam int PC_W    = cnt_width(2 * CLK_DIV);
    localparam int BC_W    = cnt_width(FRAME_W + 1);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(2 * CLK_DIV - 1);
    localparam logic [PC_W-1:0] PC_HIGH = PC_W'(CLK_DIV);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0] BC_DATA = BC_W'(PREAMBLE_W + ADDR_W);

    state_t               state_q;
    state_t               state_d;
    logic [PC_W-1:0]      pc_q;
    logic [BC_W-1:0]      bc_q;
    logic [FRAME_W-1:0]   shreg_q;
    logic                 rd_flag_q;
    logic [DATA_W-1:0]    rx_q;
    logic                 rd_valid_q;
    logic [DATA_W-1:0]    rd_data_q;

    logic                 pc_term;
    logic                 data_phase;
    logic [PC_W-1:0]      pc_next;
    logic [PREAMBLE_W-1:0] preamble;
    logic [FRAME_W-1:0]   frame;

    assign pc_term    = (pc_q == PC_LAST);
    assign pc_next    = pc_term ? '0 : pc_q + PC_W'(1);
    assign data_phase = (bc_q >= BC_DATA);

    // The top preamble bit carries the read flag; the rest comes from PREAMBLE_VAL.
    always_comb begin
        preamble                 = PREAMBLE_VAL;
        preamble[PREAMBLE_W-1]   = cfg_read_i;
        frame                    = {preamble, cfg_addr_i, cfg_data_i};
    end

    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        busy_o      = 1'b1;
        sclk_o      = 1'b0;
        sdata_oe_o  = 1'b0;
        strobe_n_o  = 1'b1;
        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cfg_valid_i) begin
                    state_d = LEAD;
                end
            end
            LEAD: begin
                sdata_oe_o = 1'b1;
                if (pc_term) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                strobe_n_o = 1'b0;
                sclk_o     = (pc_q >= PC_HIGH);
                // Reads turn the pin around for the data field so the ADC can drive it.
                sdata_oe_o = !(rd_flag_q && data_phase);
                if (pc_term && (bc_q == BC_LAST)) begin
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                if (pc_term) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The shift register only moves at the end of a bit period, so sdata_o
    // changes exactly when pc returns to 0.
    assign sdata_o    = sdata_oe_o & shreg_q[FRAME_W-1];
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            bc_q       <= '0;
            shreg_q    <= '0;
            rd_flag_q  <= 1'b0;
            rx_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        shreg_q   <= frame;
                        rd_flag_q <= cfg_read_i;
                        pc_q      <= '0;
                        bc_q      <= '0;
                        rx_q      <= '0;
                    end
                end
                LEAD: begin
                    pc_q <= pc_next;
                end
                SHIFT: begin
                    pc_q <= pc_next;
                    // Sample on the first high cycle of sclk.
                    if (rd_flag_q && data_phase && (pc_q == PC_HIGH)) begin
                        rx_q <= {rx_q[DATA_W-2:0], sdata_i};
                    end
                    if (pc_term && (bc_q != BC_LAST)) begin
                        bc_q    <= bc_q + BC_W'(1);
                        shreg_q <= shreg_q << 1;
                    end
                end
                TRAIL: begin
                    pc_q <= pc_next;
                    if (pc_term) begin
                        rd_valid_q <= 1'b1;
                        if (rd_flag_q) begin
                            rd_data_q <= rx_q;
                        end
                    end
                end
                default: begin
                    pc_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adc3wire_master.sv
// rtl/adc3wire_master.sv - N-channel 3-wire serial configuration master for ADC control registers
//
// Ports (all per-channel buses are flattened, channel c at [c*W +: W]):
//   wb_clk_i, wb_rst_ni          clock and synchronous active-low reset
//   cfg_valid_i / cfg_ready_o    per-channel request handshake
//   cfg_read_i, cfg_addr_i,
//   cfg_data_i                   per-channel request fields
//   rd_valid_o, rd_data_o        completion pulse and held readback word
//   busy_o                       channel not idle
//   sclk_o, sdata_o, sdata_oe_o,
//   sdata_i, strobe_n_o          serial pins towards the ADC IOBs
module adc3wire_master #(
    parameter int                    NUM_CH       = 2,
    parameter int                    ADDR_W       = 4,
    parameter int                    DATA_W       = 16,
    parameter int                    PREAMBLE_W   = 12,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE_VAL = 12'h001,
    parameter int                    CLK_DIV      = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic [NUM_CH-1:0]        cfg_valid_i,
    output logic [NUM_CH-1:0]        cfg_ready_o,
    input  logic [NUM_CH-1:0]        cfg_read_i,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] cfg_data_i,
    output logic [NUM_CH-1:0]        rd_valid_o,
    output logic [NUM_CH*DATA_W-1:0] rd_data_o,
    output logic [NUM_CH-1:0]        busy_o,
    output logic [NUM_CH-1:0]        sclk_o,
    output logic [NUM_CH-1:0]        sdata_o,
    output logic [NUM_CH-1:0]        sdata_oe_o,
    input  logic [NUM_CH-1:0]        sdata_i,
    output logic [NUM_CH-1:0]        strobe_n_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc3wire_engine #(
            .ADDR_W       (ADDR_W),
            .DATA_W       (DATA_W),
            .PREAMBLE_W   (PREAMBLE_W),
            .PREAMBLE_VAL (PREAMBLE_VAL),
            .CLK_DIV      (CLK_DIV)
        ) u_engine (
            .wb_clk_i    (wb_clk_i),
            .wb_rst_ni   (wb_rst_ni),
            .cfg_valid_i (cfg_valid_i[c]),
            .cfg_ready_o (cfg_ready_o[c]),
            .cfg_read_i  (cfg_read_i[c]),
            .cfg_addr_i  (cfg_addr_i[c*ADDR_W +: ADDR_W]),
            .cfg_data_i  (cfg_data_i[c*DATA_W +: DATA_W]),
            .rd_valid_o  (rd_valid_o[c]),
            .rd_data_o   (rd_data_o[c*DATA_W +: DATA_W]),
            .busy_o      (busy_o[c]),
            .sclk_o      (sclk_o[c]),
            .sdata_o     (sdata_o[c]),
            .sdata_oe_o  (sdata_oe_o[c]),
            .sdata_i     (sdata_i[c]),
            .strobe_n_o  (strobe_n_o[c])
        );
    end

endmodule

// File: tb/tb_adc3wire_master.sv
// tb/tb_adc3wire_master.sv - self-checking bench for adc3wire_master
module tb_adc3wire_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters, two channels
    logic        rstn_a;
    logic [1:0]  valid_a, rdy_a, read_a, rdv_a, busy_a, sclk_a, sdo_a, oe_a, sdi_a, stb_a;
    logic [7:0]  addr_a;
    logic [31:0] data_a, rdd_a;

    // Instance B: CLK_DIV=1, three channels, 8-bit data
    logic        rstn_b;
    logic [2:0]  valid_b, rdy_b, read_b, rdv_b, busy_b, sclk_b, sdo_b, oe_b, sdi_b, stb_b;
    logic [11:0] addr_b;
    logic [23:0] data_b, rdd_b;

    adc3wire_master #(.NUM_CH(2)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rstn_a), .cfg_valid_i(valid_a), .cfg_ready_o(rdy_a),
        .cfg_read_i(read_a), .cfg_addr_i(addr_a), .cfg_data_i(data_a), .rd_valid_o(rdv_a),
        .rd_data_o(rdd_a), .busy_o(busy_a), .sclk_o(sclk_a), .sdata_o(sdo_a),
        .sdata_oe_o(oe_a), .sdata_i(sdi_a), .strobe_n_o(stb_a)
    );

    adc3wire_master #(.NUM_CH(3), .DATA_W(8), .CLK_DIV(1)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rstn_b), .cfg_valid_i(valid_b), .cfg_ready_o(rdy_b),
        .cfg_read_i(read_b), .cfg_addr_i(addr_b), .cfg_data_i(data_b), .rd_valid_o(rdv_b),
        .rd_data_o(rdd_b), .busy_o(busy_b), .sclk_o(sclk_b), .sdata_o(sdo_b),
        .sdata_oe_o(oe_b), .sdata_i(sdi_b), .strobe_n_o(stb_b)
    );

    // Serial monitors: cumulative counters, tests work on differences
    logic [31:0] cap0 = '0, cap1 = '0, oecap1 = '0;
    logic [23:0] capb = '0;
    int np0 = 0, np1 = 0, nn1 = 0, npb = 0;
    int slow0 = 0, busy0_cnt = 0, hi_run = 0, last_run = 0;
    int lowb = 0, togerr = 0;
    logic ps_b = 1'b0, pv_b = 1'b0;

    always @(posedge sclk_a[0]) begin cap0 = {cap0[30:0], sdo_a[0]}; np0++; end
    always @(posedge sclk_a[1]) begin
        cap1   = {cap1[30:0], sdo_a[1]};
        oecap1 = {oecap1[30:0], oe_a[1]};
        np1++;
    end
    always @(negedge sclk_a[1]) nn1++;
    always @(posedge sclk_b[2]) begin capb = {capb[22:0], sdo_b[2]}; npb++; end

    always @(posedge clk) begin
        if (!stb_a[0]) slow0++;
        if (busy_a[0]) busy0_cnt++;
        if (stb_a[0]) hi_run++;
        else begin
            if (hi_run != 0) last_run = hi_run;
            hi_run = 0;
        end
        if (!stb_b[2]) begin
            if (pv_b && (sclk_b[2] == ps_b)) togerr++;
            ps_b = sclk_b[2];
            pv_b = 1'b1;
            lowb++;
        end else begin
            pv_b = 1'b0;
        end
    end

    // ADC model for channel 1: drives adc_word MSB-first during the data bits
    logic [15:0] adc_word = '0;
    int          adc_base = 0;
    int          adc_k;
    logic        adc_bit;
    always_comb begin
        adc_k   = nn1 - adc_base;
        adc_bit = 1'b0;
        if (adc_k >= 16 && adc_k < 32) adc_bit = adc_word[31-adc_k];
    end
    assign sdi_a = {adc_bit, 1'b0};
    assign sdi_b = 3'b000;

    // Present a request on instance A and return the edge on which it was taken
    task automatic issue_a(input int ch, input logic rd, input logic [3:0] a, input logic [15:0] d,
                           output int acc, output bit ok);
        ok  = 1'b0;
        acc = 0;
        @(negedge clk);
        read_a[ch]          = rd;
        addr_a[ch*4 +: 4]   = a;
        data_a[ch*16 +: 16] = d;
        valid_a[ch]         = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (rdy_a[ch]) begin
                acc = cyc + 1;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        valid_a[ch] = 1'b0;
    endtask

    // Wait (at negedges) for the completion pulse; rv is the edge that samples it
    task automatic wait_rv_a(input int ch, output int rv, output bit ok);
        ok = 1'b0;
        rv = 0;
        for (int i = 0; i < 5000; i++) begin
            if (rdv_a[ch]) begin
                rv = cyc + 1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Hold valid on channel 0 across two frames, switching payload gap cycles after the first accept
    task automatic run_pair(input logic [3:0] a1, input logic [15:0] d1,
                            input logic [3:0] a2, input logic [15:0] d2, input int gap,
                            output int acc1, output int rv1, output int rv2,
                            output logic [31:0] f1, output logic [31:0] f2,
                            output int np_f1, output int np_tot,
                            output logic rdy_at_rv1, output logic busy_after, output bit ok);
        int base;
        ok = 1'b1; acc1 = 0; rv1 = 0; rv2 = 0; f1 = '0; f2 = '0;
        np_f1 = 0; np_tot = 0; rdy_at_rv1 = 1'b0; busy_after = 1'b0;
        base = np0;
        @(negedge clk);
        read_a[0] = 1'b0; addr_a[3:0] = a1; data_a[15:0] = d1; valid_a[0] = 1'b1;
        begin : wait_acc
            for (int i = 0; i < 2000; i++) begin
                if (rdy_a[0]) begin acc1 = cyc + 1; disable wait_acc; end
                @(negedge clk);
            end
            ok = 1'b0;
        end
        @(negedge clk);
        repeat (gap) @(negedge clk);
        addr_a[3:0] = a2; data_a[15:0] = d2;
        begin : wait_r1
            for (int i = 0; i < 5000; i++) begin
                if (rdv_a[0]) begin
                    rv1 = cyc + 1; f1 = cap0; np_f1 = np0 - base; rdy_at_rv1 = rdy_a[0];
                    disable wait_r1;
                end
                @(negedge clk);
            end
            ok = 1'b0;
        end
        @(negedge clk);
        busy_after = busy_a[0];
        valid_a[0] = 1'b0;
        begin : wait_r2
            for (int i = 0; i < 5000; i++) begin
                if (rdv_a[0]) begin
                    rv2 = cyc + 1; f2 = cap0; np_tot = np0 - base;
                    disable wait_r2;
                end
                @(negedge clk);
            end
            ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn_a = 1'b0; rstn_b = 1'b0;
        valid_a = 2'b01; read_a = '0; addr_a = '0; data_a = '0;
        valid_b = 3'b100; read_b = '0; addr_b = '0; data_b = '0;
        repeat (3) @(negedge clk);
        rstn_a = 1'b1; rstn_b = 1'b1; valid_a = '0; valid_b = '0;
        checks++; if (rdy_a !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", rdy_a); end
        checks++; if (busy_a !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", busy_a); end
        checks++; if ({sclk_a, sdo_a, oe_a, rdv_a} !== 8'h00) begin errors++;
            $display("FAIL reset_pins got sclk=%b sdata=%b oe=%b rdv=%b want all 0", sclk_a, sdo_a, oe_a, rdv_a); end
        checks++; if (stb_a !== 2'b11) begin errors++; $display("FAIL reset_strobe got %b want 11", stb_a); end
        checks++; if (rdd_a !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rdd_a); end
        @(negedge clk);
        checks++; if ({busy_a, busy_b} !== 5'b0) begin errors++;
            $display("FAIL reset_req_dropped got busy_a=%b busy_b=%b want 0", busy_a, busy_b); end
    endtask

    task automatic test_write();
        int acc, rv, bnp, bslow;
        bit ok1, ok2;
        bnp = np0; bslow = slow0;
        issue_a(0, 1'b0, 4'h5, 16'hA3C1, acc, ok1);
        checks++; if (!ok1) begin errors++; $display("FAIL write_accept got timeout want accept"); end
        checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", busy_a[0]); end
        wait_rv_a(0, rv, ok2);
        checks++; if (!ok2 || (rv - acc) != 545) begin errors++;
            $display("FAIL write_latency got %0d (ok=%0d) want 545", rv - acc, ok2); end
        checks++; if (cap0 !== 32'h0015A3C1) begin errors++; $display("FAIL write_frame got %h want 0015a3c1", cap0); end
        checks++; if (np0 - bnp != 32) begin errors++; $display("FAIL write_pulses got %0d want 32", np0 - bnp); end
        checks++; if (slow0 - bslow != 512) begin errors++; $display("FAIL write_strobe_low got %0d want 512", slow0 - bslow); end
        checks++; if (rdd_a !== 32'h0) begin errors++; $display("FAIL write_rd_data_held got %h want 0", rdd_a); end
        checks++; if (rdy_a[0] !== 1'b1) begin errors++; $display("FAIL write_ready_return got %b want 1", rdy_a[0]); end
    endtask

    task automatic test_read();
        int acc, rv, bnp, bbusy;
        bit ok1, ok2;
        adc_word = 16'hBEEF; adc_base = nn1; bnp = np1; bbusy = busy0_cnt;
        issue_a(1, 1'b1, 4'h2, 16'h7777, acc, ok1);
        wait_rv_a(1, rv, ok2);
        checks++; if (!ok1 || !ok2 || (rv - acc) != 545) begin errors++;
            $display("FAIL read_latency got %0d (ok=%0d%0d) want 545", rv - acc, ok1, ok2); end
        checks++; if (cap1[31] !== 1'b1) begin errors++; $display("FAIL read_first_bit got %b want 1", cap1[31]); end
        checks++; if (cap1 !== 32'h80120000) begin errors++; $display("FAIL read_frame got %h want 80120000", cap1); end
        checks++; if (oecap1 !== 32'hFFFF0000) begin errors++; $display("FAIL read_oe got %h want ffff0000", oecap1); end
        checks++; if (np1 - bnp != 32) begin errors++; $display("FAIL read_pulses got %0d want 32", np1 - bnp); end
        checks++; if (rdd_a[31:16] !== 16'hBEEF) begin errors++; $display("FAIL read_data got %h want beef", rdd_a[31:16]); end
        checks++; if (rdd_a[15:0] !== 16'h0) begin errors++; $display("FAIL read_ch0_data got %h want 0", rdd_a[15:0]); end
        checks++; if (busy0_cnt != bbusy) begin errors++; $display("FAIL read_ch0_idle got %0d busy cycles want 0", busy0_cnt - bbusy); end
        adc_word = '0;
    endtask

    task automatic test_back_to_back();
        int acc1, rv1, rv2, npf1, nptot;
        logic [31:0] f1, f2;
        logic ra, ba;
        bit ok;
        run_pair(4'h1, 16'h1111, 4'h2, 16'h2222, 0, acc1, rv1, rv2, f1, f2, npf1, nptot, ra, ba, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got timeout want two completions"); end
        checks++; if (ra !== 1'b1 || ba !== 1'b1) begin errors++;
            $display("FAIL b2b_accept_on_rv got ready=%b busy_after=%b want 1 1", ra, ba); end
        checks++; if (f1 !== 32'h00111111) begin errors++; $display("FAIL b2b_frame1 got %h want 00111111", f1); end
        checks++; if (f2 !== 32'h00122222) begin errors++; $display("FAIL b2b_frame2 got %h want 00122222", f2); end
        checks++; if (npf1 != 32 || nptot != 64) begin errors++;
            $display("FAIL b2b_pulses got %0d/%0d want 32/64", npf1, nptot); end
        checks++; if ((rv2 - rv1) != 545) begin errors++; $display("FAIL b2b_second_latency got %0d want 545", rv2 - rv1); end
        // TRAIL (16) + one IDLE cycle at the handover + LEAD (16)
        checks++; if (last_run != 33) begin errors++; $display("FAIL b2b_strobe_gap got %0d want 33", last_run); end
    endtask

    task automatic test_valid_while_busy();
        int acc1, rv1, rv2, npf1, nptot;
        logic [31:0] f1, f2;
        logic ra, ba;
        bit ok;
        run_pair(4'h3, 16'h1234, 4'h3, 16'hFFFF, 100, acc1, rv1, rv2, f1, f2, npf1, nptot, ra, ba, ok);
        checks++; if (!ok || (rv1 - acc1) != 545) begin errors++;
            $display("FAIL vwb_latency got %0d (ok=%0d) want 545", rv1 - acc1, ok); end
        checks++; if (f1 !== 32'h00131234) begin errors++; $display("FAIL vwb_frame_latched got %h want 00131234", f1); end
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL vwb_pending_started got %b want 1", ba); end
        checks++; if (f2 !== 32'h0013FFFF) begin errors++; $display("FAIL vwb_pending_frame got %h want 0013ffff", f2); end
    endtask

    task automatic test_reset_mid_shift();
        int acc, rv, bnp, rv_seen;
        bit ok1, ok2, reached;
        bnp = np0; reached = 1'b0; rv_seen = 0;
        issue_a(0, 1'b0, 4'h4, 16'h5555, acc, ok1);
        for (int i = 0; i < 2000; i++) begin
            if (np0 - bnp == 11) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++; if (!reached || stb_a[0] !== 1'b0) begin errors++;
            $display("FAIL rst_mid_in_shift got reached=%0d strobe_n=%b want 1 0", reached, stb_a[0]); end
        rstn_a = 1'b0;
        @(negedge clk);
        checks++; if ({sclk_a[0], stb_a[0], oe_a[0], rdy_a[0], rdv_a[0], busy_a[0]} !== 6'b010100) begin errors++;
            $display("FAIL rst_mid_state got sclk=%b strobe_n=%b oe=%b ready=%b rdv=%b busy=%b want 0 1 0 1 0 0",
                     sclk_a[0], stb_a[0], oe_a[0], rdy_a[0], rdv_a[0], busy_a[0]); end
        rstn_a = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rdv_a[0]) rv_seen++;
        end
        checks++; if (rv_seen != 0) begin errors++; $display("FAIL rst_mid_no_rdv got %0d pulses want 0", rv_seen); end
        issue_a(0, 1'b0, 4'h6, 16'h0F0F, acc, ok1);
        wait_rv_a(0, rv, ok2);
        checks++; if (!ok1 || !ok2 || (rv - acc) != 545) begin errors++;
            $display("FAIL rst_mid_recover_latency got %0d (ok=%0d%0d) want 545", rv - acc, ok1, ok2); end
        checks++; if (cap0 !== 32'h00160F0F) begin errors++; $display("FAIL rst_mid_recover_frame got %h want 00160f0f", cap0); end
    endtask

    task automatic test_clkdiv1();
        int acc, rv, bnp, blow, btog;
        bit ok1, ok2;
        acc = 0; rv = 0; ok1 = 1'b0; ok2 = 1'b0;
        bnp = npb; blow = lowb; btog = togerr;
        @(negedge clk);
        read_b[2] = 1'b0; addr_b[11:8] = 4'h9; data_b[23:16] = 8'h5A; valid_b[2] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rdy_b[2]) begin acc = cyc + 1; ok1 = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        valid_b[2] = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rdv_b[2]) begin rv = cyc + 1; ok2 = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok1 || !ok2 || (rv - acc) != 53) begin errors++;
            $display("FAIL div1_latency got %0d (ok=%0d%0d) want 53", rv - acc, ok1, ok2); end
        checks++; if (capb !== 24'h00195A) begin errors++; $display("FAIL div1_frame got %h want 00195a", capb); end
        checks++; if (npb - bnp != 24) begin errors++; $display("FAIL div1_pulses got %0d want 24", npb - bnp); end
        checks++; if (lowb - blow != 48) begin errors++; $display("FAIL div1_strobe_low got %0d want 48", lowb - blow); end
        checks++; if (togerr != btog) begin errors++; $display("FAIL div1_toggle got %0d stalls want 0", togerr - btog); end
        checks++; if (rdd_b !== 24'h0) begin errors++; $display("FAIL div1_rd_data got %h want 0", rdd_b); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_valid_while_busy();
        test_reset_mid_shift();
        test_clkdiv1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
